// File: rtl/tick_meter_pkg.sv
// Shared types and default parameters for the tick period meter.
// Build option: define TICK_METER_SYNC_EN to put a two-flop synchronizer
// in front of the edge detector (for tick sources asynchronous to Clk).
package tick_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } tick_meter_state_t;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_LOCK_COUNT = 4;
    localparam int DEF_TIMEOUT    = 200;

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for the measured strobe.
// Build option: TICK_METER_SYNC_EN inserts a two-flop synchronizer (reset
// to 0) ahead of the delay register; otherwise tick_in is used directly.
// The edge output is combinational from registered/synchronous signals, so
// a held-high input produces exactly one edge cycle.
module tick_edge_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic tick_in,
    output logic tick_edge
);

    logic tick_s;
    logic tick_prev;

`ifdef TICK_METER_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer for asynchronous strobe sources.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], tick_in};
        end
    end

    assign tick_s = sync_q[1];
`else
    assign tick_s = tick_in;
`endif

    // One-cycle delayed copy of the strobe for edge detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tick_prev <= 1'b0;
        end else begin
            tick_prev <= tick_s;
        end
    end

    assign tick_edge = tick_s & ~tick_prev;

endmodule

// File: rtl/tick_period_meter.sv
// Measures Clk cycles between rising edges of tick_in, reports each period,
// asserts locked after LOCK_COUNT consecutive identical periods and pulses
// timeout when no edge arrives for TIMEOUT cycles.
// Build option: TICK_METER_SYNC_EN (synchronizer inside tick_edge_detect).
//
// Handshake: period_valid is a single-cycle strobe with no back-pressure;
// period is stable from the cycle period_valid is high until the next
// period_valid. timeout is a single-cycle strobe; period holds across it.
module tick_period_meter
    import tick_meter_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             tick_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int MATCH_W = (LOCK_COUNT > 2) ? $clog2(LOCK_COUNT) : 1;
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(TIMEOUT);

    tick_meter_state_t state_q, state_d;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MATCH_W-1:0] match_q, match_d, match_inc;
    logic               has_prev_q, has_prev_d;
    logic [CNT_W-1:0]   period_d;
    logic               period_valid_d;
    logic               locked_d;
    logic               timeout_d;
    logic               tick_edge;

    tick_edge_detect u_edge (
        .Clk       (Clk),
        .Reset     (Reset),
        .tick_in   (tick_in),
        .tick_edge (tick_edge)
    );

    // Saturating increment of the consecutive-match counter.
    assign match_inc = (match_q == MATCH_MAX) ? match_q : match_q + 1'b1;

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, counter, match and output logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        match_d        = match_q;
        has_prev_d     = has_prev_q;
        period_d       = period;
        period_valid_d = 1'b0;
        locked_d       = locked;
        timeout_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // No earlier edge exists, so the first edge only starts the count.
                has_prev_d = 1'b0;
                locked_d   = 1'b0;
                if (tick_edge) begin
                    cnt_d   = CNT_W'(1);
                    match_d = '0;
                    state_d = MEASURE;
                end
            end

            MEASURE, LOCKED: begin
                if (tick_edge) begin
                    // An edge wins over a coincident timeout.
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    cnt_d          = CNT_W'(1);
                    has_prev_d     = 1'b1;
                    if (has_prev_q && (cnt_q == period)) begin
                        match_d = match_inc;
                        if (match_inc == MATCH_MAX) begin
                            locked_d = 1'b1;
                            state_d  = LOCKED;
                        end
                    end else begin
                        match_d  = '0;
                        locked_d = 1'b0;
                        state_d  = MEASURE;
                    end
                end else if (cnt_q == CNT_LIMIT) begin
                    timeout_d  = 1'b1;
                    locked_d   = 1'b0;
                    match_d    = '0;
                    has_prev_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q        <= '0;
            match_q      <= '0;
            has_prev_q   <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            match_q      <= match_d;
            has_prev_q   <= has_prev_d;
            period       <= period_d;
            period_valid <= period_valid_d;
            locked       <= locked_d;
            timeout      <= timeout_d;
        end
    end

endmodule
